// File: rtl/ta_reg_pkg.sv
// Shared op codes and init FSM encoding for the Tsetlin-automaton state bank.
// Imported by ta_state_cell and ta_state_register.
package ta_reg_pkg;

    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_LOAD = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_INIT = 1'b1;

endpackage

// File: rtl/ta_state_cell.sv
// One saturating WIDTH-bit Tsetlin-automaton state register.
// Ports: clk, rst_n (sync, active low), op, load_data, init_wr, state_q.
module ta_state_cell
    import ta_reg_pkg::*;
#(
    parameter int WIDTH       = 3,
    parameter int RESET_VALUE = 2**(WIDTH-1)-1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] load_data,
    input  logic             init_wr,
    output logic [WIDTH-1:0] state_q
);

    localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= RST_VAL;
        end else if (init_wr) begin
            // Sweep write wins over any op on this channel.
            state_q <= RST_VAL;
        end else begin
            unique case (op)
                OP_HOLD: state_q <= state_q;
                OP_INC:  if (state_q != MAX_VAL) state_q <= state_q + WIDTH'(1);
                OP_DEC:  if (state_q != '0) state_q <= state_q - WIDTH'(1);
                OP_LOAD: state_q <= load_data;
            endcase
        end
    end

endmodule

// File: rtl/ta_state_register.sv
// Bank of NUM_TA Tsetlin-automaton state registers with a sequential init sweep.
// Ports: clk, rst_n (sync, active low), init_start, init_busy, op_valid,
//   op_ready, op[2*NUM_TA], load_data[WIDTH*NUM_TA], state_q, action.
// Optional macro TA_REG_SAT_FLAG_EN adds sat_hi/sat_lo flag outputs.
module ta_state_register
    import ta_reg_pkg::*;
#(
    parameter int NUM_TA      = 4,
    parameter int WIDTH       = 3,
    parameter int RESET_VALUE = 2**(WIDTH-1)-1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    init_start,
    output logic                    init_busy,
    input  logic                    op_valid,
    output logic                    op_ready,
    input  logic [2*NUM_TA-1:0]     op,
    input  logic [WIDTH*NUM_TA-1:0] load_data,
    output logic [WIDTH*NUM_TA-1:0] state_q,
`ifdef TA_REG_SAT_FLAG_EN
    output logic [NUM_TA-1:0]       sat_hi,
    output logic [NUM_TA-1:0]       sat_lo,
`endif
    output logic [NUM_TA-1:0]       action
);

    localparam int IDX_W = (NUM_TA > 1) ? $clog2(NUM_TA) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_TA-1);

    logic [0:0]       fsm_q;
    logic [IDX_W-1:0] idx_q;
    logic             accept;

    assign init_busy = (fsm_q == ST_INIT);
    assign op_ready  = ~init_busy;
    assign accept    = op_valid & op_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q <= ST_IDLE;
            idx_q <= '0;
        end else begin
            unique case (fsm_q)
                ST_IDLE: begin
                    if (init_start) begin
                        fsm_q <= ST_INIT;
                        idx_q <= '0;
                    end
                end
                ST_INIT: begin
                    if (idx_q == IDX_LAST) begin
                        fsm_q <= ST_IDLE;
                        idx_q <= '0;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                default: begin
                    fsm_q <= ST_IDLE;
                    idx_q <= '0;
                end
            endcase
        end
    end

    for (genvar i = 0; i < NUM_TA; i++) begin : g_cell
        logic [1:0] cell_op;
        logic       cell_wr;

        // Unaccepted ops collapse to HOLD so cells never see stale codes.
        assign cell_op = accept ? op[2*i +: 2] : OP_HOLD;
        assign cell_wr = init_busy && (idx_q == IDX_W'(i));

        ta_state_cell #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_cell (
            .clk       (clk),
            .rst_n     (rst_n),
            .op        (cell_op),
            .load_data (load_data[WIDTH*i +: WIDTH]),
            .init_wr   (cell_wr),
            .state_q   (state_q[WIDTH*i +: WIDTH])
        );

        assign action[i] = state_q[WIDTH*i + WIDTH-1];

`ifdef TA_REG_SAT_FLAG_EN
        assign sat_hi[i] = (state_q[WIDTH*i +: WIDTH] == {WIDTH{1'b1}});
        assign sat_lo[i] = (state_q[WIDTH*i +: WIDTH] == '0);
`endif
    end

endmodule

// File: tb/tb_ta_state_register.sv
// Directed bench for ta_state_register (NUM_TA=4, WIDTH=3, RESET_VALUE=3).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_ta_state_register;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init_start;
    logic        init_busy;
    logic        op_valid;
    logic        op_ready;
    logic [7:0]  op;
    logic [11:0] load_data;
    logic [11:0] state_q;
    logic [3:0]  action;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ta_state_register #(
        .NUM_TA      (4),
        .WIDTH       (3),
        .RESET_VALUE (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_start (init_start),
        .init_busy  (init_busy),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op         (op),
        .load_data  (load_data),
        .state_q    (state_q),
        .action     (action)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Load every channel with the same value in one accepted op.
    task automatic load_all(input logic [2:0] v);
        op        = 8'hFF;
        load_data = {v, v, v, v};
        op_valid  = 1'b1;
        tick();
        op_valid  = 1'b0;
        op        = 8'h00;
    endtask

    localparam logic [11:0] ALL3 = 12'h6DB;
    localparam logic [11:0] ALL4 = 12'h924;
    localparam logic [11:0] ALL7 = 12'hFFF;

    logic [2:0]  inc_exp [6] = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd7, 3'd7};
    logic [2:0]  dec_exp [5] = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
    // Sweep from all-7: ch0..ch3 return to 3 one per cycle.
    logic [11:0] swp7    [4] = '{12'hFFB, 12'hFDB, 12'hEDB, 12'h6DB};
    // Sweep from all-0.
    logic [11:0] swp0    [4] = '{12'h003, 12'h01B, 12'h0DB, 12'h6DB};

    initial begin
        rst_n      = 1'b0;
        init_start = 1'b0;
        op_valid   = 1'b0;
        op         = 8'h00;
        load_data  = 12'h000;

        tick();
        check("rst_state", state_q, ALL3);
        check("rst_action", action, 4'b0000);
        check("rst_busy", init_busy, 1'b0);
        check("rst_ready", op_ready, 1'b1);
        rst_n = 1'b1;

        op       = 8'b00_00_00_01;
        op_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("inc_ch0_%0d", i), state_q[2:0], inc_exp[i]);
            check($sformatf("inc_act0_%0d", i), action[0], 1'b1);
        end
        check("inc_others", state_q[11:3], 9'o333);

        op = 8'b00_00_10_00;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("dec_ch1_%0d", i), state_q[5:3], dec_exp[i]);
        end
        op_valid = 1'b0;

        do_reset();
        check("rst2_state", state_q, ALL3);
        op        = 8'b11_10_01_00;
        load_data = {3'd5, 9'd0};
        op_valid  = 1'b1;
        tick();
        op_valid  = 1'b0;
        check("mixed_state", state_q, {3'd5, 3'd2, 3'd4, 3'd3});
        check("mixed_action", action, 4'b1010);

        load_all(3'd7);
        check("load7", state_q, ALL7);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check("sw_busy_start", init_busy, 1'b1);
        check("sw_hold_start", state_q, ALL7);
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("sw_state_%0d", i), state_q, swp7[i]);
            check($sformatf("sw_busy_%0d", i), init_busy, (i < 3) ? 1'b1 : 1'b0);
        end
        check("sw_ready_end", op_ready, 1'b1);

        load_all(3'd0);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        check("blk_ready", op_ready, 1'b0);
        op       = 8'h55;
        op_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("blk_state_%0d", i), state_q, swp0[i]);
        end
        op_valid = 1'b0;
        check("blk_final", state_q, ALL3);

        op         = 8'h55;
        op_valid   = 1'b1;
        init_start = 1'b1;
        tick();
        op_valid   = 1'b0;
        init_start = 1'b0;
        check("same_state", state_q, ALL4);
        check("same_busy", init_busy, 1'b1);
        repeat (4) tick();
        check("same_final", state_q, ALL3);
        check("same_idle", init_busy, 1'b0);

        load_all(3'd0);
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        tick();
        tick();
        check("mid_partial", state_q, 12'h01B);
        do_reset();
        check("mid_state", state_q, ALL3);
        check("mid_idle", init_busy, 1'b0);
        check("mid_ready", op_ready, 1'b1);

        load_all(3'd0);
        init_start = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("rs_state_%0d", i), state_q, swp0[i]);
        end
        init_start = 1'b0;
        check("rs_idle", init_busy, 1'b0);
        tick();
        check("rs_idle2", init_busy, 1'b0);
        check("rs_final", state_q, ALL3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
